// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-memory req/ready access with timeout abort,
// MEM/WB register and the forwarding/stall outputs used by the earlier stages.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_rs2_data,
  input  logic [4:0]  EX_rd,
  input  logic        EX_memread,
  input  logic        EX_memwrite,
  input  logic        EX_memtoreg,
  input  logic        EX_regwrite,
  output logic [31:0] EX_MEM_ALU_result,
  output logic [4:0]  EX_MEM_rd,
  output logic        EX_MEM_regwrite,
  output logic        EX_MEM_memtoreg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_stall,
  output logic        MEM_fault,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite,
  output logic [31:0] MEM_WB_result
);

  // Handshake: dmem_req stays high with addr/we/wdata stable until the cycle
  // dmem_ready is sampled high (access completes on that edge) or the wait
  // counter reaches TIMEOUT_CYCLES (access aborted on that edge).
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic [31:0] r_alu, r_rs2;
  logic [4:0]  r_rd;
  logic        r_memread, r_memwrite, r_memtoreg, r_regwrite;
  logic        r_fault;
  logic [4:0]  r_wb_rd;
  logic        r_wb_rw;
  logic [31:0] r_wb_res;

  logic w_mem_op, w_req, w_abort, w_stall, w_abort_load;

  assign w_mem_op     = r_memread | r_memwrite;
  assign w_abort      = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES)) && !dmem_ready;
  assign w_stall      = w_req & ~dmem_ready & ~w_abort;
  // memread+memwrite together behaves as a store, so it is never an aborted load
  assign w_abort_load = w_abort & r_memread & ~r_memwrite;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req = w_mem_op;
        if (w_mem_op && !dmem_ready) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (dmem_ready || w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_abort) r_fault <= 1'b1;
    end
  end

  // EX/MEM: hold while stalled (flush ignored), bubble on flush, else capture EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!w_stall) begin
      if (flush) begin
        r_alu      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_memtoreg <= 1'b0;
        r_regwrite <= 1'b0;
      end else begin
        r_alu      <= EX_ALU_result;
        r_rs2      <= EX_rs2_data;
        r_rd       <= EX_rd;
        r_memread  <= EX_memread;
        r_memwrite <= EX_memwrite;
        r_memtoreg <= EX_memtoreg;
        r_regwrite <= EX_regwrite;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_rd  <= '0;
      r_wb_rw  <= 1'b0;
      r_wb_res <= '0;
    end else if (w_stall) begin
      r_wb_rd  <= '0;
      r_wb_rw  <= 1'b0;
      r_wb_res <= '0;
    end else begin
      r_wb_rd  <= r_rd;
      r_wb_rw  <= r_regwrite & (r_rd != 5'd0) & ~w_abort_load;
      r_wb_res <= r_memtoreg ? dmem_rdata : r_alu;
    end
  end

  assign EX_MEM_ALU_result = r_alu;
  assign EX_MEM_rd         = r_rd;
  assign EX_MEM_regwrite   = r_regwrite;
  assign EX_MEM_memtoreg   = r_memtoreg;
  assign dmem_req          = w_req;
  assign dmem_we           = r_memwrite;
  assign dmem_addr         = r_alu;
  assign dmem_wdata        = r_rs2;
  assign MEM_stall         = w_stall;
  assign MEM_fault         = r_fault;
  assign MEM_WB_rd         = r_wb_rd;
  assign MEM_WB_regwrite   = r_wb_rw;
  assign MEM_WB_result     = r_wb_res;

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage with TIMEOUT_CYCLES=4.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] EX_ALU_result, EX_rs2_data;
  logic [4:0]  EX_rd;
  logic        EX_memread, EX_memwrite, EX_memtoreg, EX_regwrite;
  logic [31:0] EX_MEM_ALU_result;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_regwrite, EX_MEM_memtoreg;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        MEM_stall, MEM_fault;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite;
  logic [31:0] MEM_WB_result;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .EX_ALU_result(EX_ALU_result), .EX_rs2_data(EX_rs2_data), .EX_rd(EX_rd),
    .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_memtoreg(EX_memtoreg), .EX_regwrite(EX_regwrite),
    .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memtoreg(EX_MEM_memtoreg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .MEM_stall(MEM_stall), .MEM_fault(MEM_fault),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_regwrite(MEM_WB_regwrite),
    .MEM_WB_result(MEM_WB_result)
  );

  always #5 clk = ~clk;

  // ctl = {memread, memwrite, memtoreg, regwrite}; flags = {req, we, stall, fault}
  typedef struct {
    logic        flush;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic        rdy;
    logic [31:0] rdata;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  flags;
    logic [4:0]  w_rd;
    logic        w_rw;
    logic [31:0] w_res;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [3:0] ctl,
                       input logic rdy, input logic [31:0] rdata);
    flush         = fl;
    EX_ALU_result = alu;
    EX_rs2_data   = rs2;
    EX_rd         = rd;
    {EX_memread, EX_memwrite, EX_memtoreg, EX_regwrite} = ctl;
    dmem_ready    = rdy;
    dmem_rdata    = rdata;
  endtask

  initial begin
    // ALU op rd=5, then ALU rd=0, then flush with no stall
    tbl[0]  = '{1'b0, 32'h1234, 32'h0, 5'd5, 4'b0001, 1'b1, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 32'h0,
                5'd5, 1'b1, 32'h1234, 32'h0, 4'b0000, 5'd0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h55, 32'h0, 5'd0, 4'b0001, 1'b1, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 5'd5, 1'b1, 32'h1234};
    tbl[3]  = '{1'b1, 32'h77, 32'h0, 5'd7, 4'b0001, 1'b1, 32'h0,
                5'd0, 1'b1, 32'h55, 32'h0, 4'b0000, 5'd0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 32'h55};
    // store 0x40 then load 0x40 back to back, ready held high
    tbl[5]  = '{1'b0, 32'h40, 32'hA5A5A5A5, 5'd0, 4'b0100, 1'b1, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h40, 32'h0, 5'd6, 4'b1011, 1'b1, 32'h0,
                5'd0, 1'b0, 32'h40, 32'hA5A5A5A5, 4'b1100, 5'd0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 32'h0BADF00D,
                5'd6, 1'b1, 32'h40, 32'h0, 4'b1000, 5'd0, 1'b0, 32'h40};
    tbl[8]  = '{1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 5'd6, 1'b1, 32'h0BADF00D};
    // load 0x100, ready after 3 wait cycles; flush during stall must be ignored
    tbl[9]  = '{1'b0, 32'h100, 32'h0, 5'd9, 4'b1011, 1'b0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'hAAAA, 32'h0, 5'd10, 4'b0001, 1'b0, 32'h0,
                5'd9, 1'b1, 32'h100, 32'h0, 4'b1010, 5'd0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 32'hAAAA, 32'h0, 5'd10, 4'b0001, 1'b0, 32'h0,
                5'd9, 1'b1, 32'h100, 32'h0, 4'b1010, 5'd0, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'hAAAA, 32'h0, 5'd10, 4'b0001, 1'b0, 32'h0,
                5'd9, 1'b1, 32'h100, 32'h0, 4'b1010, 5'd0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'hAAAA, 32'h0, 5'd10, 4'b0001, 1'b1, 32'hDEADBEEF,
                5'd9, 1'b1, 32'h100, 32'h0, 4'b1000, 5'd0, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0,
                5'd10, 1'b1, 32'hAAAA, 32'h0, 4'b0000, 5'd9, 1'b1, 32'hDEADBEEF};
    // load 0x200 never acknowledged: abort after 4 wait cycles, fault sticky
    tbl[15] = '{1'b0, 32'h200, 32'h0, 5'd11, 4'b1011, 1'b0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0000, 5'd10, 1'b1, 32'hAAAA};
    for (int k = 16; k <= 19; k++)
      tbl[k] = '{1'b0, 32'hC0DE, 32'h0, 5'd12, 4'b0001, 1'b0, 32'h12345678,
                 5'd11, 1'b1, 32'h200, 32'h0, 4'b1010, 5'd0, 1'b0, 32'h0};
    tbl[20] = '{1'b0, 32'hC0DE, 32'h0, 5'd12, 4'b0001, 1'b0, 32'h12345678,
                5'd11, 1'b1, 32'h200, 32'h0, 4'b1000, 5'd0, 1'b0, 32'h0};
    tbl[21] = '{1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0,
                5'd12, 1'b1, 32'hC0DE, 32'h0, 4'b0001, 5'd11, 1'b0, 32'h12345678};
    tbl[22] = '{1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0,
                5'd0, 1'b0, 32'h0, 32'h0, 4'b0001, 5'd12, 1'b1, 32'hC0DE};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].flush, tbl[i].alu, tbl[i].rs2, tbl[i].rd, tbl[i].ctl,
            tbl[i].rdy, tbl[i].rdata);
      #1;
      chk($sformatf("v%0d ex_mem_rd", i), 32'(EX_MEM_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d ex_mem_regwrite", i), 32'(EX_MEM_regwrite), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d ex_mem_alu", i), EX_MEM_ALU_result, tbl[i].addr);
      chk($sformatf("v%0d dmem_addr", i), dmem_addr, tbl[i].addr);
      chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, tbl[i].wdata);
      chk($sformatf("v%0d req_we_stall_fault", i),
          32'({dmem_req, dmem_we, MEM_stall, MEM_fault}), 32'(tbl[i].flags));
      chk($sformatf("v%0d mem_wb_rd", i), 32'(MEM_WB_rd), 32'(tbl[i].w_rd));
      chk($sformatf("v%0d mem_wb_regwrite", i), 32'(MEM_WB_regwrite), 32'(tbl[i].w_rw));
      chk($sformatf("v%0d mem_wb_result", i), MEM_WB_result, tbl[i].w_res);
      @(negedge clk);
    end

    // Reset asserted mid-WAIT (fault still set from the timeout above)
    drive(1'b0, 32'h300, 32'h0, 5'd13, 4'b1011, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
    #1;
    chk("rst_seq memtoreg", 32'(EX_MEM_memtoreg), 32'd1);
    chk("rst_seq idle req_stall", 32'({dmem_req, MEM_stall}), 32'b11);
    @(negedge clk);
    #1;
    chk("rst_seq wait req_stall_fault", 32'({dmem_req, MEM_stall, MEM_fault}), 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async req", 32'(dmem_req), 32'd0);
    chk("rst_async stall", 32'(MEM_stall), 32'd0);
    chk("rst_async wb_regwrite", 32'(MEM_WB_regwrite), 32'd0);
    chk("rst_async fault", 32'(MEM_fault), 32'd0);
    chk("rst_async ex_mem_rd", 32'(EX_MEM_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the stage must be idle and pass a plain ALU op
    drive(1'b0, 32'h3333, 32'h0, 5'd3, 4'b0001, 1'b1, 32'h0);
    #1;
    chk("post_rst req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 32'h0);
    #1;
    chk("post_rst stall", 32'(MEM_stall), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst wb_rd", 32'(MEM_WB_rd), 32'd3);
    chk("post_rst wb_regwrite", 32'(MEM_WB_regwrite), 32'd1);
    chk("post_rst wb_result", MEM_WB_result, 32'h3333);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
